// File: rtl/echo_pkg.sv
// Shared definitions for the parametrised echo processor: sample FSM state
// codes, default ADC/DAC zero codes and the signed saturation helper.
package echo_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_CALC  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam logic [9:0] ADC_OFFSET_DEF = 10'h181;
    localparam logic [9:0] DAC_OFFSET_DEF = 10'h200;

    // Clamp a signed value into the range of a signed w-bit word.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                    input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/echo_ram_2p.sv
// Simple dual-port delay-line RAM: one write port, one read port with a
// single registered read cycle. Contents are never cleared.
module echo_ram_2p #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/echo_processor_param.sv
// Parametrised single-tap echo processor: five-cycle sample FSM, circular
// delay line with warm-up muting, saturating mix and delay readout.
module echo_processor_param
    import echo_pkg::*;
#(
    parameter int                DATA_W      = 10,
    parameter int                ADDR_W      = 13,
    parameter int                SEL_W       = 9,
    parameter int                DELAY_SHIFT = 4,
    parameter logic [DATA_W-1:0] ADC_OFFSET  = DATA_W'(ADC_OFFSET_DEF),
    parameter logic [DATA_W-1:0] DAC_OFFSET  = DATA_W'(DAC_OFFSET_DEF),
    parameter int                DELAY_UNIT  = 1638,
    parameter bit                ECHO_SUB    = 1'b1
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  delay_sel,
    input  logic [1:0]        gain_sel,
    input  logic              mode,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic [19:0]       delay,
    output logic              busy
);

    logic                     dv_q;
    logic [2:0]               state_q, state_d;
    logic [DATA_W-1:0]        din_q, din_d;
    logic [ADDR_W-1:0]        d_q, d_d;
    logic [1:0]               gain_q, gain_d;
    logic                     mode_q, mode_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic signed [DATA_W-1:0] xc_q, xc_d;
    logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]        fill_q, fill_d;
    logic [DATA_W-1:0]        data_out_q, data_out_d;
    logic                     out_valid_q, out_valid_d;
    logic [19:0]              delay_q, delay_d;

    logic                     start;
    logic [ADDR_W-1:0]        d_in;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     ram_re, ram_we;
    logic [DATA_W-1:0]        ram_wdata;
    logic [DATA_W-1:0]        ram_rdata;

    logic signed [DATA_W:0]   x_raw;
    logic signed [DATA_W-1:0] x_clamp;
    logic signed [DATA_W-1:0] ram_s, echo_shift, echo;
    logic signed [DATA_W+1:0] y_wide;
    logic signed [DATA_W-1:0] y_sat;
    logic                     echo_on;

    assign start   = data_valid & ~dv_q;
    assign d_in    = ADDR_W'(delay_sel) << DELAY_SHIFT;
    assign rd_addr = wr_ptr_q - d_in;

    echo_ram_2p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sysclk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Mix datapath; the echo stays muted until the line holds d valid samples.
    always_comb begin
        x_raw      = $signed({1'b0, din_q}) - $signed({1'b0, ADC_OFFSET});
        x_clamp    = DATA_W'(saturate(32'(x_raw), DATA_W));
        ram_s      = $signed(ram_rdata);
        echo_shift = ram_s >>> gain_q;
        echo_on    = (gain_q != 2'd0) && (d_q != '0) && !(fill_q < d_q);
        echo       = echo_on ? echo_shift : '0;
        if (ECHO_SUB) begin
            y_wide = (DATA_W+2)'(x_clamp) - (DATA_W+2)'(echo);
        end else begin
            y_wide = (DATA_W+2)'(x_clamp) + (DATA_W+2)'(echo);
        end
        y_sat = DATA_W'(saturate(32'(y_wide), DATA_W));
    end

    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        d_d         = d_q;
        gain_d      = gain_q;
        mode_d      = mode_q;
        y_d         = y_q;
        xc_d        = xc_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        delay_d     = delay_q;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_wdata   = mode_q ? $unsigned(xc_q) : $unsigned(y_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                din_d   = data_in;
                d_d     = d_in;
                gain_d  = gain_sel;
                mode_d  = mode;
                delay_d = 20'(delay_sel) * 20'(DELAY_UNIT);
                ram_re  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_CALC;
            end
            ST_CALC: begin
                xc_d    = x_clamp;
                y_d     = y_sat;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                ram_we      = ~rst;
                data_out_d  = $unsigned(y_q) + DAC_OFFSET;
                out_valid_d = 1'b1;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                fill_d      = (&fill_q) ? fill_q : fill_q + 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            dv_q        <= 1'b0;
            state_q     <= ST_IDLE;
            din_q       <= '0;
            d_q         <= '0;
            gain_q      <= '0;
            mode_q      <= 1'b0;
            y_q         <= '0;
            xc_q        <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            data_out_q  <= DAC_OFFSET;
            out_valid_q <= 1'b0;
            delay_q     <= '0;
        end else begin
            dv_q        <= data_valid;
            state_q     <= state_d;
            din_q       <= din_d;
            d_q         <= d_d;
            gain_q      <= gain_d;
            mode_q      <= mode_d;
            y_q         <= y_d;
            xc_q        <= xc_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            delay_q     <= delay_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign delay     = delay_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_echo_processor_param.sv
// Scoreboard bench for echo_processor_param: one subtracting and one adding
// instance share stimulus and are checked against a sample-history model.
module tb_echo_processor_param;

    logic       sysclk;
    logic       rst;
    logic       data_valid;
    logic [9:0] data_in;
    logic [8:0] delay_sel;
    logic [1:0] gain_sel;
    logic       mode;

    logic [9:0]  data_out_sub, data_out_add;
    logic        out_valid_sub, out_valid_add;
    logic [19:0] delay_sub, delay_add;
    logic        busy_sub, busy_add;

    int compared;
    int mismatched;

    logic [9:0] exp_sub[$];
    logic [9:0] exp_add[$];
    int         hist_sub[$];
    int         hist_add[$];

    echo_processor_param #(.ECHO_SUB(1'b1)) dut_sub (
        .sysclk     (sysclk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .delay_sel  (delay_sel),
        .gain_sel   (gain_sel),
        .mode       (mode),
        .data_out   (data_out_sub),
        .out_valid  (out_valid_sub),
        .delay      (delay_sub),
        .busy       (busy_sub)
    );

    echo_processor_param #(.ECHO_SUB(1'b0)) dut_add (
        .sysclk     (sysclk),
        .rst        (rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .delay_sel  (delay_sel),
        .gain_sel   (gain_sel),
        .mode       (mode),
        .data_out   (data_out_add),
        .out_valid  (out_valid_add),
        .delay      (delay_add),
        .busy       (busy_add)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference: y[n] = x[n] -/+ (stored[n-d] >>> gain), stored = y or x by mode.
    task automatic modelSample(input logic [9:0] din, input logic [8:0] sel,
                               input logic [1:0] gain, input logic md);
        int x, d, e, y;
        x = clampInt(int'(din) - 385, -512, 511);
        d = int'(sel) * 16;
        for (int k = 0; k < 2; k++) begin
            e = 0;
            if (gain != 2'd0 && d != 0) begin
                if (k == 0 && hist_sub.size() >= d) e = hist_sub[hist_sub.size() - d] >>> gain;
                if (k == 1 && hist_add.size() >= d) e = hist_add[hist_add.size() - d] >>> gain;
            end
            y = clampInt((k == 0) ? x - e : x + e, -512, 511);
            if (k == 0) begin
                hist_sub.push_back(md ? x : y);
                if (hist_sub.size() > 8192) void'(hist_sub.pop_front());
                exp_sub.push_back(10'(y + 512));
            end else begin
                hist_add.push_back(md ? x : y);
                if (hist_add.size() > 8192) void'(hist_add.pop_front());
                exp_add.push_back(10'(y + 512));
            end
        end
    endtask

    // Raises data_valid for one cycle; returns while the DUT is in its read state.
    task automatic applyStimulus(input logic [9:0] din, input logic [8:0] sel,
                                 input logic [1:0] gain, input logic md);
        @(posedge sysclk);
        #1;
        data_in    = din;
        delay_sel  = sel;
        gain_sel   = gain;
        mode       = md;
        data_valid = 1'b1;
        modelSample(din, sel, gain, md);
        @(posedge sysclk);
        #1;
        data_valid = 1'b0;
    endtask

    task automatic runSample(input logic [9:0] din, input logic [8:0] sel,
                             input logic [1:0] gain, input logic md, input int gap);
        applyStimulus(din, sel, gain, md);
        repeat (gap) @(posedge sysclk);
        #1;
        checkOutput("delay_sub", delay_sub, int'(sel) * 1638);
        checkOutput("delay_add", delay_add, int'(sel) * 1638);
    endtask

    task automatic clearModel();
        exp_sub.delete();
        exp_add.delete();
        hist_sub.delete();
        hist_add.delete();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_data_out_sub"}, data_out_sub, 10'h200);
        checkOutput({tag, "_data_out_add"}, data_out_add, 10'h200);
        checkOutput({tag, "_delay"}, delay_sub, 0);
        checkOutput({tag, "_busy"}, busy_sub, 0);
        checkOutput({tag, "_out_valid"}, out_valid_sub, 0);
    endtask

    task automatic doReset();
        @(posedge sysclk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0;
        clearModel();
        checkResetState("reset");
    endtask

    // Monitors: every DUT output pulse consumes one expected sample.
    always @(negedge sysclk) begin
        if (out_valid_sub) begin
            if (exp_sub.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL sub_unexpected_out: got 0x%0h, expected no output at %0t", data_out_sub, $time);
            end else begin
                checkOutput("sub_data_out", data_out_sub, exp_sub.pop_front());
            end
        end
        if (out_valid_add) begin
            if (exp_add.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL add_unexpected_out: got 0x%0h, expected no output at %0t", data_out_add, $time);
            end else begin
                checkOutput("add_data_out", data_out_add, exp_add.pop_front());
            end
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = 10'h181;
        delay_sel  = 9'd0;
        gain_sel   = 2'd0;
        mode       = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0;
        checkResetState("init");

        $display("[TB] silence after reset");
        for (int n = 0; n < 5; n++) runSample(10'h181, 9'd1, 2'd1, 1'b0, 3);

        $display("[TB] feedback impulse");
        doReset();
        runSample(10'h1E5, 9'd1, 2'd1, 1'b0, 3);
        for (int n = 1; n < 41; n++) runSample(10'h181, 9'd1, 2'd1, 1'b0, 3);

        $display("[TB] feed-forward impulse");
        doReset();
        runSample(10'h1E5, 9'd1, 2'd2, 1'b1, 3);
        for (int n = 1; n < 41; n++) runSample(10'h181, 9'd1, 2'd2, 1'b1, 3);

        $display("[TB] saturation");
        doReset();
        for (int n = 0; n < 40; n++) runSample(10'h3FF, 9'd1, 2'd1, 1'b1, 3);

        $display("[TB] pass-through with sel=0");
        for (int n = 0; n < 20; n++) runSample(10'($urandom), 9'd0, 2'd3, 1'b0, 3);

        $display("[TB] delay change during calc, start while busy");
        doReset();
        for (int n = 0; n < 40; n++) runSample(10'($urandom), 9'd1, 2'd1, 1'b1, 3);
        applyStimulus(10'h1E5, 9'd1, 2'd1, 1'b0);
        checkOutput("busy_in_read", busy_sub, 1);
        @(posedge sysclk);
        #1;
        data_valid = 1'b1;
        data_in    = 10'h3A0;
        @(posedge sysclk);
        #1;
        data_valid = 1'b0;
        delay_sel  = 9'd2;
        checkOutput("delay_mid_sample", delay_sub, 1638);
        repeat (1) @(posedge sysclk);
        for (int n = 0; n < 4; n++) runSample(10'($urandom), 9'd2, 2'd1, 1'b1, 3);

        $display("[TB] randomized traffic");
        doReset();
        for (int n = 0; n < 200; n++) begin
            runSample(10'($urandom), 9'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom_range(3, 5));
        end

        $display("[TB] reset during wait");
        applyStimulus(10'h2F0, 9'd3, 2'd1, 1'b0);
        @(posedge sysclk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        rst = 1'b0;
        clearModel();
        checkResetState("abort");
        repeat (4) @(posedge sysclk);
        #1;
        checkOutput("abort_data_out_hold", data_out_sub, 10'h200);

        $display("[TB] longest delay, warm-up and pointer wrap");
        doReset();
        for (int n = 0; n < 8300; n++) begin
            runSample(10'($urandom), 9'd511, 2'($urandom_range(1, 3)),
                      1'($urandom_range(0, 1)), 3);
        end

        for (int i = 0; i < 20 && (exp_sub.size() != 0 || exp_add.size() != 0); i++) begin
            @(posedge sysclk);
        end
        #1;
        checkOutput("drain_sub", exp_sub.size(), 0);
        checkOutput("drain_add", exp_add.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
